// File: rtl/lc3_program_loader.sv
// Boot loader for the LC3: consumes an ORIG/LEN/data/CSUM word stream, writes the image through the
// memory special-write port, and releases the CPU from reset only once the checksum matches.
module lc3_program_loader #(
  parameter logic [15:0] MAX_LEN      = 16'hFE00,
  parameter int unsigned WRITE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] MARSpcIn,
  output logic [15:0] MDRSpcIn,
  output logic        ldMARSpcIn,
  output logic        cpu_reset,
  output logic [15:0] start_pc,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam logic [3:0] WC = WRITE_CYCLES[3:0];

  typedef enum logic [2:0] {
    S_ORIG, S_LEN, S_DATA, S_WRITE, S_CSUM, S_RUN, S_ERR
  } state_t;

  state_t      state_q;
  logic [15:0] addr_q;
  logic [15:0] remaining_q;
  logic [15:0] sum_q;
  logic [3:0]  cnt_q;
  logic        in_ready_q;
  logic [15:0] mar_q;
  logic [15:0] mdr_q;
  logic        ld_q;
  logic        cpu_reset_q;
  logic [15:0] start_pc_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] words_q;

  logic        xfer;
  logic [15:0] addr_d;
  logic [15:0] sum_d;

  // Handshake uses only the registered ready, so in_valid never feeds back into in_ready.
  assign xfer   = in_valid & in_ready_q;
  assign addr_d = addr_q + 16'd1;
  assign sum_d  = sum_q + in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_ORIG;
      addr_q      <= 16'h0000;
      remaining_q <= 16'h0000;
      sum_q       <= 16'h0000;
      cnt_q       <= 4'd0;
      in_ready_q  <= 1'b0;
      mar_q       <= 16'h0000;
      mdr_q       <= 16'h0000;
      ld_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      start_pc_q  <= 16'h0000;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      words_q     <= 16'h0000;
    end else begin
      case (state_q)
        S_ORIG: begin
          in_ready_q <= 1'b1;
          if (xfer) begin
            addr_q     <= in_data;
            start_pc_q <= in_data;
            state_q    <= S_LEN;
          end
        end
        S_LEN: begin
          if (xfer) begin
            remaining_q <= in_data;
            if (in_data == 16'h0000) begin
              state_q <= S_CSUM;
            end else if (in_data > MAX_LEN) begin
              state_q    <= S_ERR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            mar_q      <= addr_q;
            mdr_q      <= in_data;
            sum_q      <= sum_d;
            ld_q       <= 1'b1;
            cnt_q      <= WC;
            in_ready_q <= 1'b0;
            state_q    <= S_WRITE;
          end
        end
        // Strobe stays up for WC cycles; address and data registers are untouched meanwhile.
        S_WRITE: begin
          if (cnt_q <= 4'd1) begin
            ld_q        <= 1'b0;
            addr_q      <= addr_d;
            words_q     <= words_q + 16'd1;
            remaining_q <= remaining_q - 16'd1;
            in_ready_q  <= 1'b1;
            state_q     <= (remaining_q == 16'd1) ? S_CSUM : S_DATA;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (in_data == sum_q) begin
              state_q     <= S_RUN;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        default: begin
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign MARSpcIn     = mar_q;
  assign MDRSpcIn     = mdr_q;
  assign ldMARSpcIn   = ld_q;
  assign cpu_reset    = cpu_reset_q;
  assign start_pc     = start_pc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule
